// File: rtl/memoria_datos_es_pkg.sv
// Shared definitions for the data-side bus responder: I/O register addresses,
// timer control bit positions, RAM size limit and the address decoder.
package memoria_datos_es_pkg;

  localparam int RAM_MAX = 240;

  localparam logic [7:0] DIR_PORT_OUT   = 8'hF0;
  localparam logic [7:0] DIR_PORT_IN    = 8'hF1;
  localparam logic [7:0] DIR_EDGE_FLAGS = 8'hF2;
  localparam logic [7:0] DIR_TMR_CNT    = 8'hF3;
  localparam logic [7:0] DIR_TMR_CTRL   = 8'hF4;
  localparam logic [7:0] DIR_TMR_CMP    = 8'hF5;
  localparam logic [7:0] DIR_TMR_STAT   = 8'hF6;

  localparam int TMR_CTRL_EN_BIT  = 0;
  localparam int TMR_CTRL_CLR_BIT = 1;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_PORT_OUT,
    SEL_PORT_IN,
    SEL_EDGE_FLAGS,
    SEL_TMR_CNT,
    SEL_TMR_CTRL,
    SEL_TMR_CMP,
    SEL_TMR_STAT
  } sel_e;

  // RAM occupies the bottom of the map; anything not matched is unmapped.
  function automatic sel_e decode_dir(input logic [7:0] dir, input int ram_words);
    sel_e sel;
    sel = SEL_NONE;
    if (int'(dir) < ram_words) begin
      sel = SEL_RAM;
    end else begin
      case (dir)
        DIR_PORT_OUT:   sel = SEL_PORT_OUT;
        DIR_PORT_IN:    sel = SEL_PORT_IN;
        DIR_EDGE_FLAGS: sel = SEL_EDGE_FLAGS;
        DIR_TMR_CNT:    sel = SEL_TMR_CNT;
        DIR_TMR_CTRL:   sel = SEL_TMR_CTRL;
        DIR_TMR_CMP:    sel = SEL_TMR_CMP;
        DIR_TMR_STAT:   sel = SEL_TMR_STAT;
        default:        sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/memoria_datos_es_sincronizador_entrada.sv
// Two-flop synchronizer for the external input pins plus a rising-edge
// detector on the synchronized value. The edge pulse is derived from the
// synchronized value and its one-cycle-old copy, so it is glitch-free.
module sincronizador_entrada (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] i_Datos,
  output logic [7:0] o_Sincronizado,
  output logic [7:0] o_Flanco
);

  logic [7:0] meta_q;
  logic [7:0] sinc_q;
  logic [7:0] previo_q;

  // Synchronizer chain and previous-value register for edge detection.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      meta_q   <= '0;
      sinc_q   <= '0;
      previo_q <= '0;
    end else begin
      meta_q   <= i_Datos;
      sinc_q   <= meta_q;
      previo_q <= sinc_q;
    end
  end

  assign o_Sincronizado = sinc_q;
  assign o_Flanco       = sinc_q & ~previo_q;

endmodule

// File: rtl/memoria_datos_es.sv
// Data-side bus responder: 240-byte RAM plus memory-mapped output port,
// synchronized input port with sticky edge flags and an optional prescaled
// timer with compare. Read data is combinational; writes commit on Clk.
// Optional timer block enabled by defining MEMORIA_DATOS_TIMER_EN.
module memoria_datos_es
  import memoria_datos_es_pkg::*;
#(
  parameter int RAM_WORDS    = 240,
  parameter int TMR_PRESCALE = 256
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] i_Bus_Direccion_Datos,
  input  logic [7:0] i_Bus_Datos_S,
  input  logic       i_Lectura_Escritura,
  output logic [7:0] o_Bus_Datos_E,
  input  logic [7:0] i_Puerto_E,
  output logic [7:0] o_Puerto_S,
  output logic       o_Evento
);

  localparam int RAM_N = (RAM_WORDS > RAM_MAX) ? RAM_MAX : RAM_WORDS;
  localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

  sel_e       sel;
  logic       wr;
  logic [7:0] ram_q [RAM_N];
  logic [AW-1:0] ram_idx;

  logic [7:0] port_out_q, port_out_d;
  logic [7:0] port_in;
  logic [7:0] flanco;
  logic [7:0] flags_q, flags_d;
  logic [7:0] rdata;

  assign sel     = decode_dir(i_Bus_Direccion_Datos, RAM_N);
  assign wr      = i_Lectura_Escritura;
  assign ram_idx = i_Bus_Direccion_Datos[AW-1:0];

  sincronizador_entrada u_sinc (
    .Clk            (Clk),
    .Rst            (Rst),
    .i_Datos        (i_Puerto_E),
    .o_Sincronizado (port_in),
    .o_Flanco       (flanco)
  );

  // RAM storage; deliberately not reset so contents survive Rst.
  always_ff @(posedge Clk) begin
    if (wr && sel == SEL_RAM) begin
      ram_q[ram_idx] <= i_Bus_Datos_S;
    end
  end

  // Next state for output port and edge flags; a new edge beats a W1C.
  always_comb begin
    port_out_d = port_out_q;
    flags_d    = flags_q;
    if (wr && sel == SEL_PORT_OUT) begin
      port_out_d = i_Bus_Datos_S;
    end
    if (wr && sel == SEL_EDGE_FLAGS) begin
      flags_d = flags_q & ~i_Bus_Datos_S;
    end
    flags_d = flags_d | flanco;
  end

  // Port and flag registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      port_out_q <= '0;
      flags_q    <= '0;
    end else begin
      port_out_q <= port_out_d;
      flags_q    <= flags_d;
    end
  end

`ifdef MEMORIA_DATOS_TIMER_EN
  localparam int PW = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TMR_PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cmp_q, cmp_d;
  logic          en_q, en_d;
  logic          stat_q, stat_d;
  logic          clr_wr;
  logic          tick;
  logic [7:0]    cnt_inc;

  assign clr_wr  = wr && sel == SEL_TMR_CTRL && i_Bus_Datos_S[TMR_CTRL_CLR_BIT];
  assign tick    = en_q && presc_q == PRESC_TC;
  assign cnt_inc = cnt_q + 8'd1;

  // Timer next state: clear wins over a tick, match set wins over W1C.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    stat_d  = stat_q;
    if (clr_wr) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (en_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        cnt_d = cnt_inc;
      end
    end
    if (wr && sel == SEL_TMR_CTRL) begin
      en_d = i_Bus_Datos_S[TMR_CTRL_EN_BIT];
    end
    if (wr && sel == SEL_TMR_CMP) begin
      cmp_d = i_Bus_Datos_S;
    end
    if (wr && sel == SEL_TMR_STAT && i_Bus_Datos_S[0]) begin
      stat_d = 1'b0;
    end
    if (tick && !clr_wr && cnt_inc == cmp_q) begin
      stat_d = 1'b1;
    end
  end

  // Timer registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      cmp_q   <= 8'hFF;
      en_q    <= 1'b0;
      stat_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
    end
  end
`endif

  // Combinational read mux; unmapped locations read as zero.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_RAM:        rdata = ram_q[ram_idx];
      SEL_PORT_OUT:   rdata = port_out_q;
      SEL_PORT_IN:    rdata = port_in;
      SEL_EDGE_FLAGS: rdata = flags_q;
`ifdef MEMORIA_DATOS_TIMER_EN
      SEL_TMR_CNT:    rdata = cnt_q;
      SEL_TMR_CTRL:   rdata = {7'd0, en_q};
      SEL_TMR_CMP:    rdata = cmp_q;
      SEL_TMR_STAT:   rdata = {7'd0, stat_q};
`endif
      default:        rdata = '0;
    endcase
  end

  assign o_Bus_Datos_E = rdata;
  assign o_Puerto_S    = port_out_q;
`ifdef MEMORIA_DATOS_TIMER_EN
  assign o_Evento = (|flags_q) | stat_q;
`else
  assign o_Evento = |flags_q;
`endif

endmodule

// File: tb/tb_memoria_datos_es.sv
module tb_memoria_datos_es;

  localparam int RW = 240;
  localparam int P  = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] dir, wdat, pin_drv;
  logic       we;
  logic [7:0] rdat, pout;
  logic       evt;

  always #5 Clk = ~Clk;

  memoria_datos_es #(.RAM_WORDS(RW), .TMR_PRESCALE(P)) dut (
    .Clk                   (Clk),
    .Rst                   (Rst),
    .i_Bus_Direccion_Datos (dir),
    .i_Bus_Datos_S         (wdat),
    .i_Lectura_Escritura   (we),
    .o_Bus_Datos_E         (rdat),
    .i_Puerto_E            (pin_drv),
    .o_Puerto_S            (pout),
    .o_Evento              (evt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] ram_m [256];
  bit         ram_ok [256];
  logic [7:0] pout_m, flags_m;
  logic [7:0] smp1_m, pin_m, pin_prev_m;   // pins seen 1 edge ago, PORT_IN, previous PORT_IN
  bit         en_m, stat_m;
  int         elapsed_m;                   // enabled clock cycles since last clear
  logic [7:0] cmp_m;

  function automatic logic [7:0] cnt_m();
    return 8'((elapsed_m / P) % 256);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_rd(input logic [7:0] a);
    if (int'(a) < RW) return {ram_ok[a], ram_m[a]};
    case (a)
      8'hF0: return {1'b1, pout_m};
      8'hF1: return {1'b1, pin_m};
      8'hF2: return {1'b1, flags_m};
`ifdef MEMORIA_DATOS_TIMER_EN
      8'hF3: return {1'b1, cnt_m()};
      8'hF4: return {1'b1, 7'd0, en_m};
      8'hF5: return {1'b1, cmp_m};
      8'hF6: return {1'b1, 7'd0, stat_m};
`endif
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  function automatic logic exp_evt();
`ifdef MEMORIA_DATOS_TIMER_EN
    return (|flags_m) | stat_m;
`else
    return |flags_m;
`endif
  endfunction

  task automatic model_reset();
    pout_m = 0; flags_m = 0; smp1_m = 0; pin_m = 0; pin_prev_m = 0;
    en_m = 0; stat_m = 0; elapsed_m = 0; cmp_m = 8'hFF;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] p);
    logic [7:0] rise;
    bit match;
    rise = pin_m & ~pin_prev_m;
    if (w && int'(a) < RW) begin ram_m[a] = d; ram_ok[a] = 1; end
    if (w && a == 8'hF0) pout_m = d;
    if (w && a == 8'hF2) flags_m = flags_m & ~d;
    flags_m = flags_m | rise;
    pin_prev_m = pin_m; pin_m = smp1_m; smp1_m = p;
`ifdef MEMORIA_DATOS_TIMER_EN
    match = 0;
    if (w && a == 8'hF4 && d[1]) elapsed_m = 0;
    else if (en_m) begin
      elapsed_m++;
      if (elapsed_m % P == 0 && cnt_m() == cmp_m) match = 1;
    end
    if (w && a == 8'hF6 && d[0]) stat_m = 0;
    if (match) stat_m = 1;
    if (w && a == 8'hF4) en_m = d[0];
    if (w && a == 8'hF5) cmp_m = d;
`endif
  endtask

  // One bus cycle: drive after negedge, check before posedge, advance model.
  task automatic step(input logic w, input logic [7:0] a, input logic [7:0] d, output logic [7:0] obs);
    logic [8:0] e;
    we = w; dir = a; wdat = d;
    #1;
    obs = rdat;
    e = exp_rd(a);
    if (e[8]) chk($sformatf("rd@%02h", a), rdat, e[7:0]);
    chk("puerto_s", pout, pout_m);
    chk("evento", {7'd0, evt}, {7'd0, exp_evt()});
    @(posedge Clk);
    model_edge(w, a, d, pin_drv);
    @(negedge Clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] o;
    step(1'b1, a, d, o);
  endtask

  task automatic idle(input int n);
    logic [7:0] o;
    for (int i = 0; i < n; i++) step(1'b0, 8'hF1, 8'h00, o);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] expv, input string tag);
    logic [7:0] o;
    step(1'b0, a, 8'h00, o);
    chk(tag, o, expv);
  endtask

  initial begin
    logic [7:0] a, o;
    int guard;
    for (int i = 0; i < 256; i++) begin ram_ok[i] = 0; ram_m[i] = 0; end
    model_reset();
    Rst = 1'b1; we = 0; dir = 8'hF1; wdat = 0; pin_drv = 8'h00;
    #2;
    chk("rst_puerto_s", pout, 8'h00);
    chk("rst_evento", {7'd0, evt}, 8'h00);
    chk("rst_port_in", rdat, 8'h00);
`ifdef MEMORIA_DATOS_TIMER_EN
    dir = 8'hF5; #1;
    chk("rst_tmr_cmp", rdat, 8'hFF);
`endif
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b0;

    // RAM and unmapped
    wr(8'h10, 8'h5A);
    wr(8'(RW - 1), 8'hA5);
    rd(8'h10, 8'h5A, "ram_10");
    rd(8'(RW - 1), 8'hA5, "ram_top");
    rd(8'hF8, 8'h00, "unmapped_f8");
    wr(8'hF8, 8'h77);
    rd(8'hF8, 8'h00, "unmapped_f8_wr");
    wr(8'hF1, 8'hFF);
    rd(8'hF1, 8'h00, "port_in_ro");

    // Output port and asynchronous reset
    wr(8'hF0, 8'h3C);
    chk("puerto_s_3c", pout, 8'h3C);
    rd(8'hF0, 8'h3C, "port_out_rd");
    #2 Rst = 1'b1;
    #1;
    chk("async_rst_puerto_s", pout, 8'h00);
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
    rd(8'h10, 8'h5A, "ram_retained");

    // Input synchronizer and edge flags
    pin_drv = 8'h81;
    idle(2);
    rd(8'hF1, 8'h81, "port_in_81");
    rd(8'hF2, 8'h81, "edge_flags_81");
    chk("evento_edge", {7'd0, evt}, 8'h01);
    wr(8'hF2, 8'h01);
    rd(8'hF2, 8'h80, "edge_w1c");
    wr(8'hF2, 8'hFF);
    pin_drv = 8'h01;
    idle(4);
    pin_drv = 8'h81;
    idle(2);
    wr(8'hF2, 8'h80);
    rd(8'hF2, 8'h80, "edge_set_beats_clr");
    wr(8'hF2, 8'hFF);
    rd(8'hF2, 8'h00, "edge_cleared");

`ifdef MEMORIA_DATOS_TIMER_EN
    // Timer match
    wr(8'hF5, 8'h03);
    wr(8'hF4, 8'h01);
    idle(12);
    rd(8'hF3, 8'h03, "tmr_cnt_3");
    rd(8'hF6, 8'h01, "tmr_stat_match");
    chk("evento_tmr", {7'd0, evt}, 8'h01);
    wr(8'hF6, 8'h01);
    // Wrap
    wr(8'hF4, 8'h03);
    idle(1020);
    rd(8'hF3, 8'hFF, "tmr_cnt_ff");
    idle(3);
    rd(8'hF3, 8'h00, "tmr_wrap");
    // Clear on terminal-count cycle
    guard = 0;
    while (((elapsed_m + 1) % P) != 0 && guard < 2 * P) begin idle(1); guard++; end
    chk("tc_search", 8'((elapsed_m + 1) % P), 8'h00);
    wr(8'hF4, 8'h03);
    rd(8'hF3, 8'h00, "tmr_clr_beats_tick");
    rd(8'hF4, 8'h01, "tmr_ctrl_rd");
    wr(8'hF3, 8'h55);
    rd(8'hF5, 8'h03, "tmr_cmp_rd");
`else
    wr(8'hF4, 8'h01);
    rd(8'hF3, 8'h00, "notmr_f3");
    rd(8'hF4, 8'h00, "notmr_f4");
    rd(8'hF6, 8'h00, "notmr_f6");
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic w;
      if ($urandom_range(0, 7) == 0) pin_drv = 8'($urandom);
      if ($urandom_range(0, 9) < 4) a = 8'($urandom_range(0, 255));
      else a = 8'(8'hF0 + $urandom_range(0, 8));
      w = 1'($urandom_range(0, 1));
      step(w, a, 8'($urandom), o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
